// File: rtl/nucleic_acid_sequencer_if.sv
// Sequencer host/array bundle: start/abort from the host,
// valve, pump and status lines toward the array and host.
interface nucleic_acid_sequencer_if;
  logic       start;
  logic       abort;
  logic       lysis_ctl;
  logic       wash_ctl;
  logic       elute_ctl;
  logic       horiz_ctl;
  logic       dead_end_ctl;
  logic       loop_exit_ctl;
  logic       bead_vtl_ctl;
  logic       waste_ctl;
  logic       collection_ctl;
  logic       vertical_ctl;
  logic       bead_trap_ctl;
  logic       pump1;
  logic       pump2;
  logic       pump3;
  logic       busy;
  logic       done;
  logic [2:0] step;

  modport master (
    output start, abort,
    input  lysis_ctl, wash_ctl, elute_ctl, horiz_ctl,
    input  dead_end_ctl, loop_exit_ctl, bead_vtl_ctl,
    input  waste_ctl, collection_ctl, vertical_ctl,
    input  bead_trap_ctl, pump1, pump2, pump3,
    input  busy, done, step
  );

  modport slave (
    input  start, abort,
    output lysis_ctl, wash_ctl, elute_ctl, horiz_ctl,
    output dead_end_ctl, loop_exit_ctl, bead_vtl_ctl,
    output waste_ctl, collection_ctl, vertical_ctl,
    output bead_trap_ctl, pump1, pump2, pump3,
    output busy, done, step
  );
endinterface

// File: rtl/nucleic_acid_sequencer.sv
// Extraction protocol sequencer (load/mix/trap/wash/elute).
// Ports: clk, rst_n, bus (slave: start/abort in; valves, pumps,
// busy, done, step out). Macro SEQ_ABORT_FLUSH_EN adds FLUSH.
module nucleic_acid_sequencer #(
  parameter int CW           = 16,
  parameter int PUMP_DIV     = 4,
  parameter int LOAD_CYCLES  = 64,
  parameter int MIX_STROKES  = 16,
  parameter int WASH_CYCLES  = 32,
  parameter int NUM_WASH     = 2,
  parameter int ELUTE_CYCLES = 32
) (
  input logic clk,
  input logic rst_n,
  nucleic_acid_sequencer_if.slave bus
);

  localparam longint MIXC = longint'(MIX_STROKES) * 6 * PUMP_DIV;
  localparam longint MAXV = (longint'(1) << CW) - 1;
  localparam int PW = (NUM_WASH > 1) ? $clog2(NUM_WASH) : 1;

  if (PUMP_DIV < 1 || NUM_WASH < 1) begin : g_bad_cfg
    $error("PUMP_DIV and NUM_WASH must be >= 1");
  end
  if (LOAD_CYCLES > MAXV || MIXC > MAXV ||
      WASH_CYCLES > MAXV || ELUTE_CYCLES > MAXV ||
      PUMP_DIV > MAXV) begin : g_bad_dur
    $error("duration exceeds counter width CW");
  end

  localparam logic [CW-1:0] LOAD_M1  = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] MIX_M1   = CW'(MIXC - 1);
  localparam logic [CW-1:0] WASH_M1  = CW'(WASH_CYCLES - 1);
  localparam logic [CW-1:0] ELUTE_M1 = CW'(ELUTE_CYCLES - 1);
  localparam logic [CW-1:0] DIV_M1   = CW'(PUMP_DIV - 1);
  localparam logic [PW-1:0] LAST     = PW'(NUM_WASH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MIX   = 3'd2,
    S_TRAP  = 3'd3,
    S_WASH  = 3'd4,
    S_ELUTE = 3'd5,
    S_DONE  = 3'd6
`ifdef SEQ_ABORT_FLUSH_EN
    , S_FLUSH = 3'd7
`endif
  } state_t;

`ifdef SEQ_ABORT_FLUSH_EN
  localparam state_t ABORT_TO = S_FLUSH;
`else
  localparam state_t ABORT_TO = S_IDLE;
`endif

  // Bit order: lysis wash elute horiz dead_end loop_exit
  // bead_vtl waste collection vertical bead_trap
  function automatic logic [10:0] valves(state_t s);
    case (s)
      S_LOAD:  valves = 11'b10010000010;
      S_MIX:   valves = 11'b00000000010;
      S_TRAP:  valves = 11'b00000111001;
      S_WASH:  valves = 11'b01000101011;
      S_ELUTE: valves = 11'b00101100111;
`ifdef SEQ_ABORT_FLUSH_EN
      S_FLUSH: valves = 11'b01000111010;
`endif
      default: valves = 11'b0;
    endcase
  endfunction

  function automatic logic [2:0] pat(logic [2:0] p);
    case (p)
      3'd0:    pat = 3'b100;
      3'd1:    pat = 3'b110;
      3'd2:    pat = 3'b010;
      3'd3:    pat = 3'b011;
      3'd4:    pat = 3'b001;
      default: pat = 3'b101;
    endcase
  endfunction

  state_t          state, nxt;
  logic [CW-1:0]   cnt, div, div_n;
  logic [PW-1:0]   pass;
  logic [2:0]      ph, ph_n;
  logic            pass_end, entry, pumped;
  logic [10:0]     vlv_q;
  logic [2:0]      pmp_q, step_q;
  logic            busy_q, done_q;

  always_comb begin
    nxt      = state;
    pass_end = 1'b0;
    case (state)
      S_IDLE:
        if (bus.start && !bus.abort) nxt = S_LOAD;
      S_LOAD:
        if (bus.abort) nxt = ABORT_TO;
        else if (cnt == LOAD_M1) nxt = S_MIX;
      S_MIX:
        if (bus.abort) nxt = ABORT_TO;
        else if (cnt == MIX_M1) nxt = S_TRAP;
      S_TRAP:
        if (bus.abort) nxt = ABORT_TO;
        else if (cnt == LOAD_M1) nxt = S_WASH;
      S_WASH:
        if (bus.abort) nxt = ABORT_TO;
        else if (cnt == WASH_M1) begin
          if (pass == LAST) nxt = S_ELUTE;
          else pass_end = 1'b1;
        end
      S_ELUTE:
        if (bus.abort) nxt = ABORT_TO;
        else if (cnt == ELUTE_M1) nxt = S_DONE;
`ifdef SEQ_ABORT_FLUSH_EN
      S_FLUSH:
        if (cnt == WASH_M1) nxt = S_IDLE;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // A new WASH pass restarts counter and pump like a state entry
  assign entry  = (nxt != state) || pass_end;
  assign pumped = (nxt != S_IDLE) && (nxt != S_DONE);

  always_comb begin
    div_n = '0;
    ph_n  = 3'd0;
    if (!entry && pumped) begin
      if (div == DIV_M1) begin
        ph_n = (ph == 3'd5) ? 3'd0 : ph + 3'd1;
      end else begin
        div_n = div + CW'(1);
        ph_n  = ph;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pass   <= '0;
      div    <= '0;
      ph     <= 3'd0;
      vlv_q  <= '0;
      pmp_q  <= 3'b0;
      step_q <= 3'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= (entry || nxt == S_IDLE) ? '0 : cnt + CW'(1);
      if (nxt != S_WASH) pass <= '0;
      else if (pass_end) pass <= pass + PW'(1);
      div    <= div_n;
      ph     <= ph_n;
      vlv_q  <= valves(nxt);
      pmp_q  <= pumped ? pat(ph_n) : 3'b0;
      step_q <= nxt;
      busy_q <= (nxt != S_IDLE);
      done_q <= (nxt == S_DONE);
    end
  end

  assign {bus.lysis_ctl, bus.wash_ctl, bus.elute_ctl,
          bus.horiz_ctl, bus.dead_end_ctl, bus.loop_exit_ctl,
          bus.bead_vtl_ctl, bus.waste_ctl, bus.collection_ctl,
          bus.vertical_ctl, bus.bead_trap_ctl} = vlv_q;
  assign {bus.pump1, bus.pump2, bus.pump3} = pmp_q;
  assign bus.step = step_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_nucleic_acid_sequencer.sv
// Directed bench for nucleic_acid_sequencer with small timings.
// Checks reset, full run, pumps, start/abort and async reset.
module tb_nucleic_acid_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  nucleic_acid_sequencer_if bus();

  nucleic_acid_sequencer #(
    .CW(16), .PUMP_DIV(2), .LOAD_CYCLES(8), .MIX_STROKES(1),
    .WASH_CYCLES(4), .NUM_WASH(2), .ELUTE_CYCLES(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] V_LOAD  = 11'b10010000010;
  localparam logic [10:0] V_MIX   = 11'b00000000010;
  localparam logic [10:0] V_TRAP  = 11'b00000111001;
  localparam logic [10:0] V_WASH  = 11'b01000101011;
  localparam logic [10:0] V_ELUTE = 11'b00101100111;
  localparam logic [10:0] V_FLUSH = 11'b01000111010;

  logic [2:0] mix_pat [12] = '{3'b100, 3'b100, 3'b110,
    3'b110, 3'b010, 3'b010, 3'b011, 3'b011, 3'b001,
    3'b001, 3'b101, 3'b101};

  function automatic logic [10:0] vlv();
    return {bus.lysis_ctl, bus.wash_ctl, bus.elute_ctl,
            bus.horiz_ctl, bus.dead_end_ctl, bus.loop_exit_ctl,
            bus.bead_vtl_ctl, bus.waste_ctl, bus.collection_ctl,
            bus.vertical_ctl, bus.bead_trap_ctl};
  endfunction

  function automatic logic [2:0] pmp();
    return {bus.pump1, bus.pump2, bus.pump3};
  endfunction

  // k = cycles after the edge that sampled start
  function automatic logic [2:0] exp_step(int k);
    if (k < 8)  return 3'd1;
    if (k < 20) return 3'd2;
    if (k < 28) return 3'd3;
    if (k < 36) return 3'd4;
    if (k < 42) return 3'd5;
    if (k == 42) return 3'd6;
    return 3'd0;
  endfunction

  function automatic logic [10:0] exp_vlv(logic [2:0] s);
    case (s)
      3'd1: return V_LOAD;
      3'd2: return V_MIX;
      3'd3: return V_TRAP;
      3'd4: return V_WASH;
      3'd5: return V_ELUTE;
      3'd7: return V_FLUSH;
      default: return 11'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at k=0 (just after start was sampled)
  task automatic kick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({vlv(), pmp(), bus.busy, bus.done, bus.step} !== 19'b0) begin
      errors++;
      $display("FAIL reset: outs=%b want 0", {vlv(), pmp(),
        bus.busy, bus.done, bus.step});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.step !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: step=%0d busy=%b want 0 0",
        bus.step, bus.busy);
    end
  endtask

  task automatic test_full_run();
    logic [2:0] s;
    kick();
    for (int k = 0; k <= 44; k++) begin
      s = exp_step(k);
      checks++;
      if (bus.step !== s) begin
        errors++;
        $display("FAIL run_step k=%0d: got %0d want %0d",
          k, bus.step, s);
      end
      checks++;
      if (bus.done !== (k == 42) || bus.busy !== (s != 3'd0)) begin
        errors++;
        $display("FAIL run_flags k=%0d: done=%b busy=%b want %b %b",
          k, bus.done, bus.busy, k == 42, s != 3'd0);
      end
      checks++;
      if (vlv() !== exp_vlv(s)) begin
        errors++;
        $display("FAIL run_valves k=%0d: got %b want %b",
          k, vlv(), exp_vlv(s));
      end
      if (k >= 8 && k < 20) begin
        checks++;
        if (pmp() !== mix_pat[k-8]) begin
          errors++;
          $display("FAIL mix_pump k=%0d: got %b want %b",
            k, pmp(), mix_pat[k-8]);
        end
      end
      if (s == 3'd0 || s == 3'd6) begin
        checks++;
        if (pmp() !== 3'b000) begin
          errors++;
          $display("FAIL pump_off k=%0d: got %b want 000", k, pmp());
        end
      end
      if (k == 0 || k == 20 || k == 28 || k == 36) begin
        checks++;
        if (pmp() !== 3'b100) begin
          errors++;
          $display("FAIL pump_entry k=%0d: got %b want 100",
            k, pmp());
        end
      end
      tick();
    end
  endtask

  task automatic test_start_in_wash();
    int ndone = 0;
    int at = -1;
    kick();
    for (int k = 0; k <= 46; k++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        at = k;
      end
      checks++;
      if (bus.step !== exp_step(k)) begin
        errors++;
        $display("FAIL wash_start_step k=%0d: got %0d want %0d",
          k, bus.step, exp_step(k));
      end
      bus.start = (k == 30);
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (ndone != 1 || at != 42) begin
      errors++;
      $display("FAIL wash_start_done: count=%0d at=%0d want 1 at 42",
        ndone, at);
    end
  endtask

  task automatic test_abort_trap();
    int ndone = 0;
    kick();
    for (int k = 0; k < 22; k++) tick();
    checks++;
    if (bus.step !== 3'd3) begin
      errors++;
      $display("FAIL abort_pre: step=%0d want 3", bus.step);
    end
    bus.abort = 1'b1;
    for (int k = 23; k <= 30; k++) begin
      tick();
      bus.abort = (k < 25);
      if (bus.done === 1'b1) ndone++;
`ifdef SEQ_ABORT_FLUSH_EN
      checks++;
      if (k <= 26) begin
        if (bus.step !== 3'd7 || vlv() !== V_FLUSH ||
            bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL flush k=%0d: step=%0d v=%b busy=%b",
            k, bus.step, vlv(), bus.busy);
        end
      end else if (bus.step !== 3'd0 || vlv() !== 11'b0) begin
        errors++;
        $display("FAIL flush_end k=%0d: step=%0d v=%b want 0",
          k, bus.step, vlv());
      end
`else
      checks++;
      if (bus.step !== 3'd0 || vlv() !== 11'b0 ||
          pmp() !== 3'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL abort k=%0d: step=%0d v=%b p=%b busy=%b",
          k, bus.step, vlv(), pmp(), bus.busy);
      end
`endif
    end
    bus.abort = 1'b0;
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort_done: pulses=%0d want 0", ndone);
    end
  endtask

  task automatic test_idle_start_abort();
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.step !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: step=%0d busy=%b want 0 0",
        bus.step, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    kick();
    for (int k = 0; k < 38; k++) tick();
    checks++;
    if (bus.step !== 3'd5) begin
      errors++;
      $display("FAIL mid_pre: step=%0d want 5", bus.step);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vlv(), pmp(), bus.busy, bus.done, bus.step} !== 19'b0) begin
      errors++;
      $display("FAIL mid_reset: outs=%b want 0", {vlv(), pmp(),
        bus.busy, bus.done, bus.step});
    end
    tick();
    rst_n = 1'b1;
    kick();
    checks++;
    if (bus.step !== 3'd1 || pmp() !== 3'b100 || vlv() !== V_LOAD) begin
      errors++;
      $display("FAIL mid_restart: step=%0d p=%b v=%b want 1 100 %b",
        bus.step, pmp(), vlv(), V_LOAD);
    end
    tick();
    tick();
    checks++;
    if (pmp() !== 3'b110 || bus.step !== 3'd1) begin
      errors++;
      $display("FAIL mid_pump: p=%b step=%0d want 110 1",
        pmp(), bus.step);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_full_run();
    test_idle_start_abort();
    test_start_in_wash();
    test_abort_trap();
    for (int i = 0; i < 3; i++) tick();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
